spfp_mul_post: RTL and testbench
================================

SPFP_MUL_POST -- requirements
Module: spfp_mul_post

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operands plus raw product present.
REQ-005 SHALL have port in_ready  output  1  block can accept; equals !full.
REQ-006 SHALL have port n1  input  32  multiplier operand A (IEEE-754 single).
REQ-007 SHALL have port n2  input  32  multiplier operand B.
REQ-008 SHALL have port z_raw  input  32  unchecked product from the combinational SPFP multiplier for n1*n2.
REQ-009 SHALL have port out_valid  output  1  FIFO head holds a result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head.
REQ-011 SHALL have port out_z  output  32  final product.
REQ-012 SHALL have port out_flags  output  5  {invalid, overflow, underflow, inf, zero}.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL accept a transfer when in_valid && in_ready, and pop when out_valid && out_ready.
REQ-015 SHALL classify each accepted input combinationally and write {z, flags} into the FIFO that cycle; the result appears at out_valid the next cycle (latency 1 when empty).
REQ-016 SHALL decode fields: e1=n1[30:23], e2=n2[30:23]; operand NaN = exp 255 and mantissa !=0; inf = exp 255 and mantissa 0; zero = exp 0 (denormals flushed to zero); s = n1[31]^n2[31].
REQ-017 SHALL derive carry = (z_raw[30:23] == (e1+e2-126) mod 256), and true exponent E = e1+e2-127+carry as a 10-bit signed value.
REQ-018 SHALL apply priority: (1) NaN operand, or inf*zero -> 0x7FC00000, invalid=1; (2) inf operand -> {s,0xFF,0}, inf=1; (3) zero operand -> {s,31'b0}, zero=1; (4) E>=255 -> {s,0xFF,0}, overflow=1, inf=1; (5) E<=0 -> {s,31'b0}, underflow=1, zero=1; (6) otherwise z_raw passed unchanged, flags 0.
REQ-019 SHALL keep in_ready low while level==DEPTH; a push is not accepted when full, even if a pop occurs in the same cycle.
REQ-020 SHALL, on simultaneous push and pop when neither empty nor full, leave level unchanged and advance both pointers.
REQ-021 SHALL ignore out_ready when empty; level never underflows and never exceeds DEPTH.
REQ-022 SHALL wrap read and write pointers modulo DEPTH and preserve FIFO ordering.
REQ-023 SHALL hold out_z and out_flags stable while out_valid && !out_ready.

Reset
REQ-024 SHALL, on rst high at a clock edge, set pointers and level to 0, out_valid=0, in_ready=1; out_z=0 and out_flags=0 when empty.
REQ-025 SHALL discard all stored entries and any same-cycle transfer when rst is asserted mid-operation; rst has priority over push and pop.
REQ-026 SHALL need no reset of FIFO storage contents.

Structure
REQ-027 SHALL take from the shared spfp package: SPFP_QNAN=32'h7FC00000, SPFP_EXP_BIAS=127, SPFP_EXP_MAX=8'hFF, and the packed flag typedef spfp_flags_t {invalid, overflow, underflow, inf, zero}.
REQ-028 SHALL separate the storage into one sub-module spfp_sync_fifo (parameters WIDTH=37, DEPTH); classification logic stays in spfp_mul_post.

Verification
REQ-029 SHALL cover 2.0*3.0: n1=0x40000000, n2=0x40400000, z_raw=0x40C00000 -> next cycle out_z=0x40C00000, out_flags=0.
REQ-030 SHALL cover inf*0: n1=0x7F800000, n2=0x00000000 -> out_z=0x7FC00000, invalid=1.
REQ-031 SHALL cover overflow: n1=n2=0x7F000000 -> E=381, out_z=0x7F800000, overflow=1, inf=1; and underflow: n1=n2=0x00800000 -> E=-125, out_z=0x00000000, underflow=1, zero=1.
REQ-032 SHALL cover full/drain: out_ready=0, push 5 times -> in_ready=0 after the 4th, level=4, 5th not accepted; then out_ready=1 -> 4 results in push order, level decrements to 0.
REQ-033 SHALL cover reset mid-stream: 3 entries queued, rst pulse -> next cycle level=0, out_valid=0, in_ready=1, and no old entry ever emerges.

Source files
------------

// File: rtl/spfp_mul_post_pkg.sv
// Shared single-precision constants and result-flag layout for the multiplier post stage.
package spfp_mul_post_pkg;

    localparam logic [31:0] SPFP_QNAN     = 32'h7FC0_0000;
    localparam int unsigned SPFP_EXP_BIAS = 127;
    localparam logic [7:0]  SPFP_EXP_MAX  = 8'hFF;

    localparam int unsigned SPFP_W       = 32;
    localparam int unsigned SPFP_FLAGS_W = 5;
    localparam int unsigned SPFP_ENTRY_W = SPFP_W + SPFP_FLAGS_W;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inf;
        logic zero;
    } spfp_flags_t;

endpackage

// File: rtl/spfp_mul_post_if.sv
// Operand/product input channel and result output channel of the multiplier post stage.
interface spfp_mul_post_if #(
    parameter int unsigned DEPTH = 4
);
    import spfp_mul_post_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      n1;
    logic [31:0]      n2;
    logic [31:0]      z_raw;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_z;
    spfp_flags_t      out_flags;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, n1, n2, z_raw, out_ready,
        input  in_ready, out_valid, out_z, out_flags, level
    );

    modport slave (
        input  in_valid, n1, n2, z_raw, out_ready,
        output in_ready, out_valid, out_z, out_flags, level
    );

endinterface

// File: rtl/spfp_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is never reset, only the pointers are.
module spfp_sync_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push is refused while full even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (count == '0);
    assign full  = (count == LVL_W'(DEPTH));
    assign level = count;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spfp_mul_post.sv
// Classifies a raw single-precision product against its operands and queues the
// corrected result with exception flags.
module spfp_mul_post
    import spfp_mul_post_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    spfp_mul_post_if.slave   bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [7:0]                e1;
    logic [7:0]                e2;
    logic                      nan1, nan2, inf1, inf2, zero1, zero2;
    logic                      sign;
    logic [9:0]                exp_sum;
    logic                      carry;
    logic signed [9:0]         exp_true;
    logic [31:0]               res_z;
    spfp_flags_t               res_flags;
    logic [SPFP_ENTRY_W-1:0]   fifo_rdata;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [LVL_W-1:0]          fifo_level;

    assign e1    = bus.n1[30:23];
    assign e2    = bus.n2[30:23];
    assign nan1  = (e1 == SPFP_EXP_MAX) && (bus.n1[22:0] != '0);
    assign nan2  = (e2 == SPFP_EXP_MAX) && (bus.n2[22:0] != '0);
    assign inf1  = (e1 == SPFP_EXP_MAX) && (bus.n1[22:0] == '0);
    assign inf2  = (e2 == SPFP_EXP_MAX) && (bus.n2[22:0] == '0);
    assign zero1 = (e1 == '0);
    assign zero2 = (e2 == '0);
    assign sign  = bus.n1[31] ^ bus.n2[31];

    // Mantissa-product normalisation shows up as a +1 on the raw product exponent.
    assign exp_sum  = 10'(e1) + 10'(e2);
    assign carry    = (bus.z_raw[30:23] == 8'(exp_sum - 10'(SPFP_EXP_BIAS - 1)));
    assign exp_true = $signed(exp_sum - 10'(SPFP_EXP_BIAS) + 10'(carry));

    always_comb begin
        res_z     = bus.z_raw;
        res_flags = '0;
        if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
            res_z             = SPFP_QNAN;
            res_flags.invalid = 1'b1;
        end else if (inf1 || inf2) begin
            res_z         = {sign, SPFP_EXP_MAX, 23'd0};
            res_flags.inf = 1'b1;
        end else if (zero1 || zero2) begin
            res_z          = {sign, 31'd0};
            res_flags.zero = 1'b1;
        end else if (exp_true >= 10'sd255) begin
            res_z              = {sign, SPFP_EXP_MAX, 23'd0};
            res_flags.overflow = 1'b1;
            res_flags.inf      = 1'b1;
        end else if (exp_true <= 10'sd0) begin
            res_z               = {sign, 31'd0};
            res_flags.underflow = 1'b1;
            res_flags.zero      = 1'b1;
        end
    end

    spfp_sync_fifo #(
        .WIDTH (SPFP_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (bus.out_ready),
        .wdata ({res_z, res_flags}),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // Head is masked to zero when empty so stale storage never reaches the outputs.
    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_z     = fifo_empty ? '0 : fifo_rdata[SPFP_ENTRY_W-1:SPFP_FLAGS_W];
    assign bus.out_flags = fifo_empty ? '0 : spfp_flags_t'(fifo_rdata[SPFP_FLAGS_W-1:0]);
    assign bus.level     = fifo_level;

endmodule

// File: tb/tb_spfp_mul_post.sv
// Directed self-checking bench for spfp_mul_post: classification vectors, full/drain and reset.
module tb_spfp_mul_post;
    import spfp_mul_post_pkg::*;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    spfp_mul_post_if #(.DEPTH(4)) bus ();

    spfp_mul_post #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
        bus.in_valid = 1'b1;
        bus.n1       = a;
        bus.n2       = b;
        bus.z_raw    = z;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Push one product with the consumer stalled, check the head, then pop it.
    task automatic classify(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] z, input logic [31:0] exp_z, input logic [4:0] exp_f);
        bus.out_ready = 1'b0;
        push_one(a, b, z);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_z"}, bus.out_z, exp_z);
        chk({tag, "_flags"}, 32'(bus.out_flags), 32'(exp_f));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_level"}, 32'(bus.level), 32'd0);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.n1        = '0;
        bus.n2        = '0;
        bus.z_raw     = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_z", bus.out_z, 32'd0);
        chk("rst_out_flags", 32'(bus.out_flags), 32'd0);

        // 2.0*3.0 with hold-while-stalled check
        push_one(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        chk("mul23_valid", 32'(bus.out_valid), 32'd1);
        chk("mul23_z", bus.out_z, 32'h40C0_0000);
        chk("mul23_flags", 32'(bus.out_flags), 32'd0);
        chk("mul23_level", 32'(bus.level), 32'd1);
        tick();
        chk("mul23_hold_z", bus.out_z, 32'h40C0_0000);
        chk("mul23_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("mul23_pop_level", 32'(bus.level), 32'd0);
        chk("mul23_pop_valid", 32'(bus.out_valid), 32'd0);

        classify("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h1234_5678, 32'h7FC0_0000, 5'b10000);
        classify("nan_op", 32'h7FA0_0001, 32'h3F80_0000, 32'h1234_5678, 32'h7FC0_0000, 5'b10000);
        classify("neg_inf", 32'hFF80_0000, 32'h4000_0000, 32'h1234_5678, 32'hFF80_0000, 5'b00010);
        classify("neg_zero", 32'h8000_0000, 32'h4000_0000, 32'h1234_5678, 32'h8000_0000, 5'b00001);
        classify("overflow", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 32'h7F80_0000, 5'b01010);
        classify("underflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 32'h0000_0000, 5'b00101);
        classify("ovf_e255", 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 32'h7F80_0000, 5'b01010);
        classify("unf_e0", 32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 32'h0000_0000, 5'b00101);
        classify("carry_pass", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 32'h4010_0000, 5'b00000);
        classify("neg_pass", 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 32'hC0C0_0000, 5'b00000);

        // Pop on empty is ignored
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("empty_pop_level", 32'(bus.level), 32'd0);

        // Fill past capacity with consumer stalled
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_in_ready_%0d", i), 32'(bus.in_ready), (i < 4) ? 32'd1 : 32'd0);
            push_one(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000 + 32'(i));
            chk($sformatf("fill_level_%0d", i), 32'(bus.level), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_z_%0d", k), bus.out_z, 32'h3F80_0000 + 32'(k));
            tick();
            chk($sformatf("drain_level_%0d", k), 32'(bus.level), 32'(3 - k));
        end
        bus.out_ready = 1'b0;
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // Push+pop while full drops the push; push+pop while partial keeps level
        for (int i = 0; i < 4; i++) push_one(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0010 + 32'(i));
        bus.out_ready = 1'b1;
        push_one(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0014);
        chk("full_pp_level", 32'(bus.level), 32'd3);
        chk("full_pp_head", bus.out_z, 32'h3F80_0011);
        push_one(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0015);
        chk("part_pp_level", 32'(bus.level), 32'd3);
        chk("part_pp_head", bus.out_z, 32'h3F80_0012);
        tick();
        chk("pp_drain0", bus.out_z, 32'h3F80_0013);
        tick();
        chk("pp_drain1", bus.out_z, 32'h3F80_0015);
        tick();
        chk("pp_drain_level", 32'(bus.level), 32'd0);
        bus.out_ready = 1'b0;

        // Reset mid-stream with a concurrent push and pop
        for (int i = 0; i < 3; i++) push_one(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0020 + 32'(i));
        chk("pre_rst_level", 32'(bus.level), 32'd3);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        push_one(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0023);
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        chk("mid_rst_level", 32'(bus.level), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_z", bus.out_z, 32'd0);
        push_one(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        chk("post_rst_z", bus.out_z, 32'h40C0_0000);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("post_rst_empty", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
